// File: rtl/fifo_nl_reader.sv
// fifo_nl_reader: turns a non-lookahead FIFO read port into a valid/ready stream; define FIFO_NL_READER_CNT_EN for the xfer_cnt output
module fifo_nl_reader #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_NL_READER_CNT_EN
  ,
  output logic [15:0]           xfer_cnt
`endif
);
  logic [DATA_WIDTH-1:0] mem [2];
  logic [1:0] cnt;
  logic inflight, rd_ptr, wr_ptr, pop;
  assign pop = m_valid && m_ready;
  assign m_valid = cnt != 2'd0;
  assign m_data = mem[rd_ptr];
  // a read is only issued when its word is guaranteed a slot on return: free space now, or a pop frees one
  assign fifo_rd = !rst && !fifo_empty && ((cnt + {1'b0, inflight}) < 2'd2 || pop);
  // track the word in flight, capture it at the tail, advance the head on pop
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 2'd0;
      inflight <= 1'b0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      inflight <= fifo_rd;
      if (inflight) begin
        mem[wr_ptr] <= fifo_dout;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, inflight} - {1'b0, pop};
    end
  end
`ifdef FIFO_NL_READER_CNT_EN
  // count completed stream handshakes, wrapping at 16 bits
  always_ff @(posedge clk) xfer_cnt <= rst ? 16'd0 : xfer_cnt + 16'(pop);
`endif
endmodule

// File: tb/tb_fifo_nl_reader.sv
// tb_fifo_nl_reader: randomized bench for fifo_nl_reader against a FIFO model and an in-order scoreboard
`timescale 1ns/1ps
module tb_fifo_nl_reader;
  localparam int W = 32;
  localparam int DEPTH = 70000;
  logic clk = 1'b0, rst = 1'b1, fifo_rd, m_valid, m_ready = 1'b0;
  logic fifo_empty;
  logic [W-1:0] fifo_dout = '0, m_data;
`ifdef FIFO_NL_READER_CNT_EN
  logic [15:0] xfer_cnt;
`endif
  int checks = 0, errors = 0;
  logic [W-1:0] fmem [DEPTH];
  int wp = 0, rp = 0;
  logic [W-1:0] outq [$];
  int n_rd = 0, n_pop = 0, uf = 0, ovf = 0;
  logic [W-1:0] vals [8] = '{32'h5A, 32'hF6, 32'h09, 32'hC4, 32'h81, 32'hE2, 32'hA0, 32'h7A};

  fifo_nl_reader #(.DATA_WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .fifo_empty(fifo_empty),
    .fifo_rd(fifo_rd),
    .fifo_dout(fifo_dout),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data)
`ifdef FIFO_NL_READER_CNT_EN
    ,
    .xfer_cnt(xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign fifo_empty = (wp == rp);

  // non-lookahead FIFO: a read returns data on the next cycle, otherwise the bus carries junk
  always @(posedge clk) begin
    if (fifo_rd && !fifo_empty) begin
      fifo_dout <= fmem[rp];
      rp <= rp + 1;
    end else fifo_dout <= $urandom;
    n_rd <= rst ? 0 : n_rd + int'(fifo_rd);
  end

  // observe mid-cycle: collect delivered words, count underflow reads and occupancy overruns
  always @(negedge clk) begin
    if (rst) begin
      n_pop = 0;
      outq.delete();
    end else begin
      if (fifo_rd && fifo_empty) uf++;
      if (n_rd - n_pop > 2) ovf++;
      if (m_valid && m_ready) begin
        outq.push_back(m_data);
        n_pop++;
      end
    end
  end

  task automatic push(input logic [W-1:0] v);
    fmem[wp] = v;
    wp++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", m_valid); end
    checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b want 0", fifo_rd); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b want 0", m_valid); end
`ifdef FIFO_NL_READER_CNT_EN
    checks++; if (xfer_cnt !== 16'h0000) begin errors++; $display("FAIL reset_xfer_cnt: got %h want 0000", xfer_cnt); end
`endif
  endtask

  task automatic test_order;
    logic exp_v;
    int uf0;
    uf0 = uf;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) push(vals[i]);
    m_ready = 1'b1;
    #1;
    checks++; if (fifo_rd !== 1'b1) begin errors++; $display("FAIL order_first_rd: got %b want 1", fifo_rd); end
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      exp_v = (c >= 2 && c < 10);
      checks++; if (m_valid !== exp_v) begin errors++; $display("FAIL order_valid[%0d]: got %b want %b", c, m_valid, exp_v); end
      if (exp_v) begin
        checks++; if (m_data !== vals[c-2]) begin errors++; $display("FAIL order_data[%0d]: got %h want %h", c, m_data, vals[c-2]); end
      end
    end
    checks++; if (uf != uf0) begin errors++; $display("FAIL order_underflow: got %0d want 0", uf - uf0); end
  endtask

  task automatic test_stall;
    int rds, base;
    rds = 0;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(vals[i]);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      rds += int'(fifo_rd);
      if (c >= 2) begin
        checks++; if (m_valid !== 1'b1 || m_data !== 32'h5A) begin errors++; $display("FAIL stall_hold[%0d]: got v=%b d=%h want v=1 d=5a", c, m_valid, m_data); end
      end
    end
    checks++; if (rds != 2) begin errors++; $display("FAIL stall_reads: got %0d want 2", rds); end
    @(posedge clk);
    #1;
    base = outq.size();
    m_ready = 1'b1;
    for (int t = 0; t < 50 && outq.size() - base < 8; t++) begin
      @(negedge clk);
      #1;
    end
    checks++; if (outq.size() - base != 8) begin errors++; $display("FAIL stall_drain_count: got %0d want 8", outq.size() - base); end
    for (int i = 0; i < 8 && base + i < outq.size(); i++) begin
      checks++; if (outq[base+i] !== vals[i]) begin errors++; $display("FAIL stall_drain[%0d]: got %h want %h", i, outq[base+i], vals[i]); end
    end
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] rem [$];
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push($urandom);
    repeat (4) @(posedge clk);
    #1;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_ready = 1'b0;
    #1;
    checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL midreset_rd: got %b want 0", fifo_rd); end
    rem.delete();
    for (int i = rp; i < wp; i++) rem.push_back(fmem[i]);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b want 0", m_valid); end
    checks++; if (fifo_rd !== 1'b1) begin errors++; $display("FAIL midreset_restart_rd: got %b want 1", fifo_rd); end
    m_ready = 1'b1;
    for (int t = 0; t < 50 && outq.size() < rem.size(); t++) begin
      @(negedge clk);
      #1;
    end
    checks++; if (outq.size() != rem.size()) begin errors++; $display("FAIL midreset_count: got %0d want %0d", outq.size(), rem.size()); end
    for (int i = 0; i < rem.size() && i < outq.size(); i++) begin
      checks++; if (outq[i] !== rem[i]) begin errors++; $display("FAIL midreset_data[%0d]: got %h want %h", i, outq[i], rem[i]); end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] exp_q [$];
    logic [W-1:0] v;
    int pushed, base, uf0, ovf0, t;
    pushed = 0;
    t = 0;
    uf0 = uf;
    ovf0 = ovf;
    base = outq.size();
    while (outq.size() - base < 1024 && t < 10000) begin
      @(posedge clk);
      #1;
      if (pushed < 1024 && $urandom_range(0, 2) != 0) begin
        v = $urandom;
        push(v);
        exp_q.push_back(v);
        pushed++;
      end
      m_ready = 1'($urandom_range(0, 1));
      t++;
    end
    m_ready = 1'b0;
    checks++; if (outq.size() - base != 1024) begin errors++; $display("FAIL random_count: got %0d want 1024", outq.size() - base); end
    for (int i = 0; i < 1024 && base + i < outq.size(); i++) begin
      checks++; if (outq[base+i] !== exp_q[i]) begin errors++; $display("FAIL random_data[%0d]: got %h want %h", i, outq[base+i], exp_q[i]); end
    end
    checks++; if (uf != uf0) begin errors++; $display("FAIL random_underflow: got %0d want 0", uf - uf0); end
    checks++; if (ovf != ovf0) begin errors++; $display("FAIL random_overflow: got %0d want 0", ovf - ovf0); end
  endtask

`ifdef FIFO_NL_READER_CNT_EN
  task automatic test_xfer_cnt;
    int t;
    t = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (xfer_cnt !== 16'h0000) begin errors++; $display("FAIL xfer_reset: got %h want 0000", xfer_cnt); end
    while (n_pop < 65537 && t < 80000) begin
      if (wp - rp < 4) push($urandom);
      m_ready = 1'b1;
      @(posedge clk);
      #1;
      t++;
    end
    m_ready = 1'b0;
    checks++; if (n_pop != 65537) begin errors++; $display("FAIL xfer_handshakes: got %0d want 65537", n_pop); end
    checks++; if (xfer_cnt !== 16'h0001) begin errors++; $display("FAIL xfer_wrap: got %h want 0001", xfer_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_order();
    test_stall();
    test_reset_mid();
    test_random();
`ifdef FIFO_NL_READER_CNT_EN
    test_xfer_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
